// File: rtl/inst_timestamper_if.sv
// Instruction-in / FIFO-out channel of the instruction timestamper.
//   in_valid, in_inst  : instruction offered by the producer
//   in_ready           : instruction taken when in_valid && in_ready
//   fifo_rd_en         : consumer read strobe
//   fifo_data          : registered head word {t_inst[19:0], opcode[6:0], angle[10:0]}
//   fifo_empty         : no stored entries
//   fifo_count         : stored entries, 0..DEPTH
// master = producer/consumer side, slave = timestamper.
interface inst_timestamper_if;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        fifo_rd_en;
  logic [37:0] fifo_data;
  logic        fifo_empty;
  logic [6:0]  fifo_count;

  modport master (
    output in_valid, in_inst, fifo_rd_en,
    input  in_ready, fifo_data, fifo_empty, fifo_count
  );

  modport slave (
    input  in_valid, in_inst, fifo_rd_en,
    output in_ready, fifo_data, fifo_empty, fifo_count
  );
endinterface

// File: rtl/inst_timestamper.sv
// Instruction timestamper. Consumes GATE/WAIT instructions after a sync,
// stamps each GATE with the running time pointer t_ptr and queues
// {t_ptr, opcode, angle} in a DEPTH-entry FIFO with a registered read port.
// A GATE stamped with too little slack against t_cnt sets a sticky late_err
// and parks the block in ERR until the next sync.
// Ports:
//   clk       : clock, all state on rising edge
//   reset     : asynchronous active-low reset
//   t_cnt     : free-running global time counter
//   sync      : one-cycle pulse, arms the block and loads t_ptr = t_cnt + LEAD
//   bus       : instruction input / FIFO output channel (slave side)
//   late_err  : sticky late-scheduling flag, cleared by sync
//   gate_cnt  : GATEs pushed since the last sync (wraps at 2^16)
module inst_timestamper #(
  parameter int          DEPTH     = 8,
  parameter logic [19:0] LEAD      = 20'd8,
  parameter logic [19:0] GATE_DUR  = 20'd1,
  parameter logic [19:0] MIN_SLACK = 20'd3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [19:0]         t_cnt,
  input  logic                sync,
  inst_timestamper_if.slave   bus,
  output logic                late_err,
  output logic [15:0]         gate_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t        state_reg, state_next;
  logic [19:0]   t_ptr_reg, t_ptr_next;
  logic          late_reg, late_next;
  logic [15:0]   gate_cnt_reg, gate_cnt_next;
  logic [6:0]    count_reg, count_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [37:0]   data_reg;
  logic [37:0]   mem [DEPTH];

  logic          is_wait;
  logic          fifo_full;
  logic          ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic [19:0]   slack;
  logic          too_late;
  logic [37:0]   push_word;

  // Bits [30:20] carry no meaning for either instruction type.
  logic unused_inst_bits;
  assign unused_inst_bits = &{1'b0, bus.in_inst[30:20]};

  assign is_wait   = bus.in_inst[31];
  assign fifo_full = (count_reg == 7'(DEPTH));
  // A WAIT never needs FIFO space, so only GATEs are held off by a full FIFO.
  assign ready     = (state_reg == RUN) && !sync && (is_wait || !fifo_full);
  assign accept    = bus.in_valid && ready;
  assign push      = accept && !is_wait;
  assign pop       = bus.fifo_rd_en && (count_reg != 7'd0);
  // Slack is a modular difference; bit 19 set means t_ptr is already behind t_cnt.
  assign slack     = t_ptr_reg - t_cnt;
  assign too_late  = slack[19] || (slack < MIN_SLACK);
  assign push_word = {t_ptr_reg, bus.in_inst[17:11], bus.in_inst[10:0]};

  always_comb begin
    state_next    = state_reg;
    t_ptr_next    = t_ptr_reg;
    late_next     = late_reg;
    gate_cnt_next = gate_cnt_reg;
    count_next    = count_reg;

    if (sync) begin
      state_next    = RUN;
      t_ptr_next    = t_cnt + LEAD;
      late_next     = 1'b0;
      gate_cnt_next = 16'd0;
    end else if (accept) begin
      if (is_wait) begin
        t_ptr_next = t_ptr_reg + bus.in_inst[19:0];
      end else begin
        t_ptr_next    = t_ptr_reg + GATE_DUR;
        gate_cnt_next = gate_cnt_reg + 16'd1;
        if (too_late) begin
          late_next  = 1'b1;
          state_next = ERR;
        end
      end
    end

    case ({push, pop})
      2'b10:   count_next = count_reg + 7'd1;
      2'b01:   count_next = count_reg - 7'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      t_ptr_reg    <= 20'd0;
      late_reg     <= 1'b0;
      gate_cnt_reg <= 16'd0;
      count_reg    <= 7'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      data_reg     <= 38'd0;
    end else begin
      state_reg    <= state_next;
      t_ptr_reg    <= t_ptr_next;
      late_reg     <= late_next;
      gate_cnt_reg <= gate_cnt_next;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        data_reg   <= mem[rd_ptr_reg];
      end
    end
  end

  // Storage is not reset: the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.fifo_data  = data_reg;
  assign bus.fifo_count = count_reg;
  assign bus.fifo_empty = (count_reg == 7'd0);
  assign late_err       = late_reg;
  assign gate_cnt       = gate_cnt_reg;

endmodule
